data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Memory-side responder for the CPU's MEM-stage load/store port. It replaces the single-cycle data memory with a word-array memory that has a configurable access latency. It accepts one request at a time, latches it, and counts out the latency. It then completes the access and returns a one-cycle acknowledge. A combinational stall output freezes the pipeline while the access is outstanding.

Parameters:
DEPTH, 32, number of 32-bit words in the array (power of two).
LATENCY, 4, cycles spent in BUSY per access; legal range ≥1.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-low.
req_i  input  1  access request from the MEM stage (load or store).
we_i  input  1  1 = store, 0 = load; sampled with req_i.
addr_i  input  32  byte address.
data_i  input  32  store data.
ack_o  output  1  one-cycle pulse; the access has completed.
data_o  output  32  load data; valid when ack_o is high for a load.
err_o  output  1  pulses together with ack_o when the access was rejected.
stall_o  output  1  pipeline freeze request.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE; ack_o=0, err_o=0, data_o=0, counter=0, request registers cleared.
  - stall_o then follows the IDLE rule below.
  - Memory array contents are not cleared; the bench preloads the array hierarchically.
- States: IDLE, BUSY, DONE.
- stall_o (combinational) = (state==IDLE && req_i) || state==BUSY.
- IDLE:
  - On an edge with req_i=1: latch we_i, addr_i, data_i; counter <= LATENCY-1; go to BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - Inputs are ignored; the latched request is authoritative.
  - counter != 0: decrement the counter.
  - counter == 0: perform the access, set ack_o<=1, go to DONE.
- Access, performed on the BUSY→DONE edge:
  - Word index = latched addr[log2(DEPTH)+1:2].
  - Store: mem[index] <= latched data; data_o is unchanged.
  - Load: data_o <= mem[index].
- Error case: latched addr[1:0]!=0, or addr[31:2] ≥ DEPTH.
  - No write occurs.
  - A load sets data_o<=0.
  - err_o<=1 alongside ack_o.
  - Latency is identical to a normal access.
- DONE:
  - ack_o (and err_o if set) is high for exactly this cycle; stall_o=0.
  - On the next edge: ack_o<=0, err_o<=0, go to IDLE.
  - req_i during DONE is ignored. It still shows the just-completed instruction; the pipeline advances at this edge.
- Timing, with the request first presented in cycle 0:
  - stall_o is high in cycles 0..LATENCY (LATENCY+1 cycles).
  - ack_o is high in cycle LATENCY+1.
- data_o holds its last value between load completions.
- Reset asserted mid-operation: return to IDLE immediately. A pending store is not written and no ack is issued.
- Counter width is clog2(LATENCY)+1. There is no wrap-around: the counter is reloaded only in IDLE.
- Only one request is outstanding at a time; no queuing.

Test Plan:
1. Store/load, LATENCY=4:
   - Store 0xDEADBEEF to 0x10 → stall_o high cycles 0-4, ack_o high only in cycle 5, err_o=0.
   - Then load 0x10 → data_o=0xDEADBEEF in its ack cycle.
2. Errors, DEPTH=32:
   - Load 0x13 → ack_o=1, err_o=1, data_o=0.
   - Store 0x12345678 to 0x80 → ack_o=1, err_o=1; a subsequent load of 0x00 returns its preloaded value unchanged.
3. Input disturbance: store 0xAAAA0000 to 0x08, then switch addr_i to 0x0C and data_i to 0xFFFFFFFF during BUSY → mem[2]=0xAAAA0000, mem[3] unchanged.
4. Held request: req_i held high through DONE → exactly one access and one ack pulse. A new load presented in the following IDLE cycle is accepted and acked 5 cycles later.
5. Reset mid-access: store 0x55555555 to 0x04, drop rst_i during BUSY → ack_o, err_o, data_o=0 immediately, no ack follows. After reset release, a load of 0x04 returns the old value.
6. LATENCY=1: load → stall_o high cycles 0-1, ack_o in cycle 2 with correct data.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-array data memory with a fixed access latency for the MEM stage.
// Ports: clk_i, rst_i (async low), req/we/addr/data in; ack/data/err/stall out.
module data_memory_responder #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          mem_we;
   logic [AW-1:0] idx;
   logic          bad;

   logic [31:0]   mem_q [DEPTH];

   assign idx = addr_q[AW+1:2];
   // DEPTH is a power of two, so any set bit above the index is out of range
   assign bad = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

   assign ack_o  = ack_q;
   assign err_o  = err_q;
   assign data_o = rdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      stall_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall_o = req_i;
            if (req_i) begin
               we_d    = we_i;
               addr_d  = addr_i;
               wdata_d = data_i;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = DONE;
               ack_d   = 1'b1;
               err_d   = bad;
               mem_we  = we_q && !bad;
               if (!we_q)
                  rdata_d = bad ? '0 : mem_q[idx];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Array is not reset; a reset during BUSY leaves state IDLE so no write fires
   always_ff @(posedge clk_i) begin
      if (mem_we)
         mem_q[idx] <= wdata_q;
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder.
// Two instances (latency 4 and 1) share inputs; sel picks the active one.
module tb_data_memory_responder;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;

   logic        req0, req1;
   logic        ack0, ack1, err0, err1, stall0, stall1;
   logic [31:0] dout0, dout1;
   logic        ack, err, stall;
   logic [31:0] dout;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mm [2][DEPTH];
   logic [31:0] expd [2];

   always #5 clk = ~clk;

   assign req0  = req & ~sel;
   assign req1  = req & sel;
   assign ack   = sel ? ack1 : ack0;
   assign err   = sel ? err1 : err0;
   assign stall = sel ? stall1 : stall0;
   assign dout  = sel ? dout1 : dout0;

   data_memory_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we),
      .addr_i(addr), .data_i(data), .ack_o(ack0), .data_o(dout0),
      .err_o(err0), .stall_o(stall0)
   );

   data_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we),
      .addr_i(addr), .data_i(data), .ack_o(ack1), .data_o(dout1),
      .err_o(err1), .stall_o(stall1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_ack", 32'(ack), 0);
         chk("idle_err", 32'(err), 0);
         chk("idle_stall", 32'(stall), 0);
         @(posedge clk); #1;
      end
   endtask

   // dmode: 0 none, 1 random disturbance, 2 fixed 0x0C/FFFFFFFF
   task automatic access(input bit s, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input int dmode);
      int lat;
      bit bad;
      int ix;
      lat = s ? 1 : 4;
      bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
      ix  = int'((a >> 2) % DEPTH);
      sel = s; req = 1'b1; we = w; addr = a; data = d;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         chk("busy_stall", 32'(stall), 1);
         chk("busy_ack", 32'(ack), 0);
         chk("busy_hold", dout, expd[s]);
         @(posedge clk); #1;
         if (c < lat && dmode == 1) begin
            we = 1'($urandom); addr = $urandom; data = $urandom;
         end else if (c < lat && dmode == 2) begin
            addr = 32'h0C; data = 32'hFFFF_FFFF;
         end
      end
      if (!bad && w) mm[s][ix] = d;
      if (!w) expd[s] = bad ? 32'h0 : mm[s][ix];
      @(negedge clk);
      chk("done_ack", 32'(ack), 1);
      chk("done_err", 32'(err), 32'(bad));
      chk("done_stall", 32'(stall), 0);
      chk("done_data", dout, expd[s]);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = {25'h0, 5'($urandom), 2'b00};
      if (k == 8) a[1:0] = 2'($urandom_range(1, 3));
      if (k == 9) a[31:7] = 25'($urandom_range(1, 32'h1FF_FFFF));
      return a;
   endfunction

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) mm[s][i] = $urandom | 32'h1;
         expd[s] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         dut0.mem_q[i] = mm[0][i];
         dut1.mem_q[i] = mm[1][i];
      end
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_ack", 32'(ack), 0);
         chk("rst_err", 32'(err), 0);
         chk("rst_data", dout, 0);
         chk("rst_stall", 32'(stall), 0);
         req = 1'b1;
         #1;
         chk("rst_stall_req", 32'(stall), 1);
         req = 1'b0;
      end
      sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      idle(1);

      access(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
      idle(1);
      access(0, 0, 32'h10, 32'h0, 0);
      access(0, 0, 32'h13, 32'h0, 0);
      access(0, 1, 32'h80, 32'h1234_5678, 0);
      access(0, 0, 32'h00, 32'h0, 0);
      access(0, 0, 32'h7C, 32'h0, 0);
      access(0, 1, 32'h08, 32'hAAAA_0000, 2);
      access(0, 0, 32'h08, 32'h0, 0);
      access(0, 0, 32'h0C, 32'h0, 0);
      idle(2);

      access(0, 0, 32'h04, 32'h0, 0);
      sel = 1'b0; req = 1'b1; we = 1'b1;
      addr = 32'h04; data = 32'h5555_5555;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_data", dout, 0);
      chk("mid_rst_stall", 32'(stall), 0);
      expd[0] = '0; expd[1] = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      idle(4);
      access(0, 0, 32'h04, 32'h0, 0);

      access(1, 0, 32'h14, 32'h0, 0);
      access(1, 1, 32'h14, 32'hCAFE_F00D, 0);
      access(1, 0, 32'h14, 32'h0, 0);
      access(1, 0, 32'h81, 32'h0, 0);
      idle(1);

      for (int n = 0; n < 250; n++) begin
         access(1'($urandom), 1'($urandom), rnd_addr(), $urandom,
                int'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++)
            access(1'(s), 0, 32'(i * 4), 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
